decode_stage: RTL
=================

Name: decode_stage

Overview:
- Registered, handshaked RV32I decode stage. It sits between fetch and execute and replaces the purely combinational decoder.
- Decodes the full control-flow, ALU-immediate, ALU-register, load/store and LUI/AUIPC subset.
- Generates sign-extended immediates, register indices, next-PC select, ALU function code and control strobes.
- Holds everything in a one-entry pipeline register with valid/ready flow control, flush and illegal-instruction detection.

Parameters:
- XLEN, 32, datapath and immediate width. Legal values: 32 or 64; immediates are sign-extended to XLEN.
- FC_W, 4, width of function_code. Must be at least 3.
- TRAP_ILLEGAL, 1, selects illegal-instruction handling:
  - 1: illegal=1 and next_pc_sel=TRAP (3'd4).
  - 0: the instruction is decoded as a NOP (all strobes 0, next_pc_sel=PC+4).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  kill the held entry and any concurrent input.
- in_valid  input  1  inst_encoding/in_pc are valid.
- in_ready  output  1  stage can accept this cycle.
- inst_encoding  input  32  raw instruction.
- in_pc  input  XLEN  PC of the instruction.
- out_valid  output  1  decoded entry is valid.
- out_ready  input  1  execute accepts the entry.
- out_pc  output  XLEN  registered in_pc.
- next_pc_sel  output  3  next-PC source:
  - 0 = PC+4
  - 1 = PC+JAL imm
  - 2 = from register file
  - 3 = PC+branch imm
  - 4 = trap
- function_code  output  FC_W  ALU operation:
  - 0 = A+B
  - 1 = A-B
  - 2 = A&B
  - 3 = A|B
  - 4 = A^B
  - 5 = SLT
  - 6 = SLTU
  - 7 = passB
- br_cond  output  3  funct3 for branches; 0 otherwise.
- rd, rs1, rs2  output  5 each  register indices (fields copied unconditionally).
- imm  output  XLEN  sign-extended immediate (I/S/B/J/U format by opcode); 0 for R-type.
- alu_src_imm  output  1  ALU B operand = imm.
- reg_we  output  1  register write enable. Forced 0 when rd=0.
- mem_re, mem_we  output  1 each  load / store strobe.
- illegal  output  1  unsupported opcode or funct combination.

Behaviour:
- Reset: all outputs are 0, including out_valid, next_pc_sel (=PC+4) and function_code (=A+B). Reset mid-transfer drops the held entry. in_ready=0 during reset.
- in_ready = !rst && !flush && (!out_valid || out_ready).
- Load: when in_valid && in_ready, all outputs register the decode of inst_encoding on the next edge and out_valid=1. Latency is 1 cycle; throughput is 1 instruction per cycle.
- Hold: when out_valid && !out_ready, all outputs remain bit-stable and in_ready=0.
- Drain: when out_ready && out_valid && no load, out_valid goes to 0 next cycle. Payload outputs keep their values (don't-care).
- Flush: the next cycle has out_valid=0, including the case where a load was offered in the same cycle. Flush has priority over load; rst has priority over flush.
- Decode is fully combinational into the register; there are no x outputs. Per instruction group:
  - JAL: sel=1, fc=A+B, reg_we.
  - JALR: sel=2, fc=A+B, alu_src_imm, reg_we.
  - BEQ/BNE: sel=3, fc=A-B.
  - BLT/BGE: sel=3, fc=SLT.
  - BLTU/BGEU: sel=3, fc=SLTU.
  - Branch funct3 010/011 is illegal.
  - OP-IMM (ADDI, SLTI, SLTIU, XORI, ORI, ANDI) and OP (ADD, SUB, SLT, SLTU, XOR, OR, AND): the corresponding fc, reg_we; alu_src_imm for OP-IMM only.
  - Shifts are illegal.
  - LW: fc=A+B, alu_src_imm, mem_re, reg_we.
  - SW: fc=A+B, alu_src_imm, mem_we.
  - Other load/store widths are illegal.
  - LUI: fc=passB, alu_src_imm, reg_we.
  - AUIPC: fc=A+B, alu_src_imm, reg_we; execute selects PC as A.
- Illegal detection:
  - Any other opcode is illegal, as is the all-zero word.
  - For OP, funct7 must be 0, or 0x20 only for SUB.
- Illegal entries always have reg_we, mem_re and mem_we all 0.
- Immediate formats:
  - B and J immediates have bit 0 = 0.
  - U immediate = inst[31:12]<<12, sign-extended for XLEN=64.

Test Plan:
- ADDI x1,x0,5 (0x00500093), pc=0x100, out_ready=1 -> next cycle:
  - out_valid=1, rd=1, imm=5, fc=0, sel=0, alu_src_imm=1, reg_we=1, out_pc=0x100.
- JAL x1,8 (0x008000EF) then BEQ x1,x2,-4 (0xFE208EE3) back-to-back:
  - JAL: sel=1, imm=8.
  - BEQ: sel=3, fc=1, imm=0xFFFFFFFC, br_cond=0, reg_we=0.
  - Both accepted on consecutive cycles.
- JALR x0,0(x1) (0x00008067) -> sel=2, rs1=1, reg_we=0 (rd=0).
- SW x2,12(x1) (0x0020A623) -> imm=12, rs1=1, rs2=2, mem_we=1, reg_we=0.
- Backpressure and flush:
  - Hold out_ready=0 with ADDI loaded and present 0x00800093 -> in_ready=0, outputs unchanged for 5 cycles.
  - Raise out_ready -> the second instruction is loaded the following cycle.
  - Assert flush with in_valid=1 -> out_valid=0 next cycle.
- 0x00000000 with TRAP_ILLEGAL=1 -> illegal=1, sel=4, all strobes 0. With TRAP_ILLEGAL=0 -> illegal=1, sel=0.
- rst asserted while out_valid=1 -> out_valid=0 and all outputs 0 on the next edge.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode captured in a one-entry valid/ready
// pipeline register, with flush, synchronous reset and illegal-instruction handling.
module decode_stage #(
    parameter int XLEN         = 32,
    parameter int FC_W         = 4,
    parameter int TRAP_ILLEGAL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst_encoding,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      next_pc_sel,
    output logic [FC_W-1:0] function_code,
    output logic [2:0]      br_cond,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm,
    output logic            alu_src_imm,
    output logic            reg_we,
    output logic            mem_re,
    output logic            mem_we,
    output logic            illegal
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    typedef enum logic [2:0] {
        SEL_PC4  = 3'd0,
        SEL_JAL  = 3'd1,
        SEL_REG  = 3'd2,
        SEL_BR   = 3'd3,
        SEL_TRAP = 3'd4
    } pc_sel_e;

    typedef enum logic [FC_W-1:0] {
        FC_ADD   = FC_W'(0),
        FC_SUB   = FC_W'(1),
        FC_AND   = FC_W'(2),
        FC_OR    = FC_W'(3),
        FC_XOR   = FC_W'(4),
        FC_SLT   = FC_W'(5),
        FC_SLTU  = FC_W'(6),
        FC_PASSB = FC_W'(7)
    } fc_e;

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [31:0]     w_imm_i;
    logic [31:0]     w_imm_s;
    logic [31:0]     w_imm_b;
    logic [31:0]     w_imm_j;
    logic [31:0]     w_imm_u;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    pc_sel_e         w_sel;
    fc_e             w_fc;
    logic [2:0]      w_br;
    logic            w_alu_imm;
    logic            w_we;
    logic            w_re;
    logic            w_mwe;
    logic            w_ill;
    logic            w_load;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [2:0]      r_sel;
    logic [FC_W-1:0] r_fc;
    logic [2:0]      r_br;
    logic [4:0]      r_rd;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [XLEN-1:0] r_imm;
    logic            r_alu_imm;
    logic            r_we;
    logic            r_re;
    logic            r_mwe;
    logic            r_ill;

    assign w_opc = inst_encoding[6:0];
    assign w_f3  = inst_encoding[14:12];
    assign w_f7  = inst_encoding[31:25];

    assign w_imm_i = {{20{inst_encoding[31]}}, inst_encoding[31:20]};
    assign w_imm_s = {{20{inst_encoding[31]}}, inst_encoding[31:25], inst_encoding[11:7]};
    assign w_imm_b = {{20{inst_encoding[31]}}, inst_encoding[7], inst_encoding[30:25],
                      inst_encoding[11:8], 1'b0};
    assign w_imm_j = {{12{inst_encoding[31]}}, inst_encoding[19:12], inst_encoding[20],
                      inst_encoding[30:21], 1'b0};
    assign w_imm_u = {inst_encoding[31:12], 12'b0};

    // All formats are built at 32 bits and sign-extended once to XLEN.
    assign w_imm = XLEN'($signed(w_imm32));

    always_comb begin
        w_sel     = SEL_PC4;
        w_fc      = FC_ADD;
        w_br      = 3'd0;
        w_alu_imm = 1'b0;
        w_we      = 1'b0;
        w_re      = 1'b0;
        w_mwe     = 1'b0;
        w_ill     = 1'b0;
        w_imm32   = '0;
        case (w_opc)
            OPC_LUI: begin
                w_imm32   = w_imm_u;
                w_fc      = FC_PASSB;
                w_alu_imm = 1'b1;
                w_we      = 1'b1;
            end
            OPC_AUIPC: begin
                w_imm32   = w_imm_u;
                w_alu_imm = 1'b1;
                w_we      = 1'b1;
            end
            OPC_JAL: begin
                w_imm32 = w_imm_j;
                w_sel   = SEL_JAL;
                w_we    = 1'b1;
            end
            OPC_JALR: begin
                w_imm32   = w_imm_i;
                w_sel     = SEL_REG;
                w_alu_imm = 1'b1;
                w_we      = 1'b1;
                w_ill     = (w_f3 != 3'b000);
            end
            OPC_BRANCH: begin
                w_imm32 = w_imm_b;
                w_sel   = SEL_BR;
                w_br    = w_f3;
                case (w_f3)
                    3'b000, 3'b001: w_fc = FC_SUB;
                    3'b100, 3'b101: w_fc = FC_SLT;
                    3'b110, 3'b111: w_fc = FC_SLTU;
                    default:        w_ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                w_imm32   = w_imm_i;
                w_alu_imm = 1'b1;
                w_re      = 1'b1;
                w_we      = 1'b1;
                w_ill     = (w_f3 != 3'b010);
            end
            OPC_STORE: begin
                w_imm32   = w_imm_s;
                w_alu_imm = 1'b1;
                w_mwe     = 1'b1;
                w_ill     = (w_f3 != 3'b010);
            end
            OPC_OPIMM: begin
                w_imm32   = w_imm_i;
                w_alu_imm = 1'b1;
                w_we      = 1'b1;
                case (w_f3)
                    3'b000:  w_fc = FC_ADD;
                    3'b010:  w_fc = FC_SLT;
                    3'b011:  w_fc = FC_SLTU;
                    3'b100:  w_fc = FC_XOR;
                    3'b110:  w_fc = FC_OR;
                    3'b111:  w_fc = FC_AND;
                    default: w_ill = 1'b1;
                endcase
            end
            OPC_OP: begin
                w_we  = 1'b1;
                w_ill = (w_f7 != 7'h00);
                case (w_f3)
                    3'b000: begin
                        w_fc  = (w_f7 == 7'h20) ? FC_SUB : FC_ADD;
                        w_ill = (w_f7 != 7'h00) && (w_f7 != 7'h20);
                    end
                    3'b010:  w_fc = FC_SLT;
                    3'b011:  w_fc = FC_SLTU;
                    3'b100:  w_fc = FC_XOR;
                    3'b110:  w_fc = FC_OR;
                    3'b111:  w_fc = FC_AND;
                    default: w_ill = 1'b1;
                endcase
            end
            default: w_ill = 1'b1;
        endcase

        if (inst_encoding[11:7] == 5'd0) begin
            w_we = 1'b0;
        end
        // Illegal entries carry no side effects; only the trap/NOP selection differs.
        if (w_ill) begin
            w_we      = 1'b0;
            w_re      = 1'b0;
            w_mwe     = 1'b0;
            w_alu_imm = 1'b0;
            w_fc      = FC_ADD;
            w_br      = 3'd0;
            w_sel     = (TRAP_ILLEGAL != 0) ? SEL_TRAP : SEL_PC4;
        end
    end

    assign in_ready = !rst && !flush && (!r_valid || out_ready);
    assign w_load   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_sel     <= '0;
            r_fc      <= '0;
            r_br      <= '0;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_imm     <= '0;
            r_alu_imm <= 1'b0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_mwe     <= 1'b0;
            r_ill     <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_pc      <= in_pc;
            r_sel     <= w_sel;
            r_fc      <= w_fc;
            r_br      <= w_br;
            r_rd      <= inst_encoding[11:7];
            r_rs1     <= inst_encoding[19:15];
            r_rs2     <= inst_encoding[24:20];
            r_imm     <= w_imm;
            r_alu_imm <= w_alu_imm;
            r_we      <= w_we;
            r_re      <= w_re;
            r_mwe     <= w_mwe;
            r_ill     <= w_ill;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid     = r_valid;
    assign out_pc        = r_pc;
    assign next_pc_sel   = r_sel;
    assign function_code = r_fc;
    assign br_cond       = r_br;
    assign rd            = r_rd;
    assign rs1           = r_rs1;
    assign rs2           = r_rs2;
    assign imm           = r_imm;
    assign alu_src_imm   = r_alu_imm;
    assign reg_we        = r_we;
    assign mem_re        = r_re;
    assign mem_we        = r_mwe;
    assign illegal       = r_ill;

endmodule
